// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between two writeback requesters:
// A (ALU result) and B (memory load data). Each requester has a one-entry
// holding buffer with a valid/ready handshake. Grants go to the older entry.
// Equal-age entries are granted round-robin, except that equal-age entries to
// the same address always grant A first.
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   A_VALID/A_ADDR/A_DATA requester A write request; A_READY = A buffer empty
//   B_VALID/B_ADDR/B_DATA requester B write request; B_READY = B buffer empty
//   WRITE/INADDRESS/IN    registered write port to reg_file
//   RD1_ADDR/RD2_ADDR     reg_file read addresses checked for hazards
//   HAZ1/HAZ2             read address matches a buffered or in-flight write
//   BUSY                  any buffer full or a write in flight
module regfile_write_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              A_VALID,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_DATA,
    output logic              A_READY,
    input  logic              B_VALID,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_DATA,
    output logic              B_READY,
    output logic              WRITE,
    output logic [ADDR_W-1:0] INADDRESS,
    output logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] RD1_ADDR,
    input  logic [ADDR_W-1:0] RD2_ADDR,
    output logic              HAZ1,
    output logic              HAZ2,
    output logic              BUSY
);

    // Buffer state
    logic              a_full, b_full;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_data, b_data;
    logic              a_old, b_old;   // entry is strictly older than the other
    logic              rr_b;           // round-robin pointer: 0 = A, 1 = B

    // Next-state signals
    logic              a_full_n, b_full_n;
    logic [ADDR_W-1:0] a_addr_n, b_addr_n;
    logic [DATA_W-1:0] a_data_n, b_data_n;
    logic              a_old_n, b_old_n;
    logic              rr_b_n;
    logic              write_n;
    logic [ADDR_W-1:0] inaddress_n;
    logic [DATA_W-1:0] in_n;

    logic acc_a, acc_b;
    logic grant_a, grant_b, rr_toggle;
    logic a_keep, b_keep;

    // Ready depends only on state, and is forced low during reset
    assign A_READY = ~a_full & ~RESET;
    assign B_READY = ~b_full & ~RESET;
    assign acc_a   = A_VALID & A_READY;
    assign acc_b   = B_VALID & B_READY;

    // Grant selection from registered buffer state only
    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        rr_toggle = 1'b0;
        if (a_full && b_full) begin
            if (a_old != b_old) begin
                grant_a = a_old;
                grant_b = b_old;
            end else if (a_addr == b_addr) begin
                // ALU result must land before the load to the same register
                grant_a = 1'b1;
            end else begin
                grant_a   = ~rr_b;
                grant_b   = rr_b;
                rr_toggle = 1'b1;
            end
        end else begin
            grant_a = a_full;
            grant_b = b_full;
        end
    end

    // Next-state for buffers, age flags, pointer and write port
    always_comb begin
        a_addr_n    = a_addr;
        a_data_n    = a_data;
        b_addr_n    = b_addr;
        b_data_n    = b_data;
        inaddress_n = INADDRESS;
        in_n        = IN;
        write_n     = 1'b0;
        rr_b_n      = rr_b ^ rr_toggle;

        // A buffer is never granted and refilled on the same edge
        a_keep   = a_full & ~grant_a;
        b_keep   = b_full & ~grant_b;
        a_full_n = a_keep | acc_a;
        b_full_n = b_keep | acc_b;

        // A surviving entry is older than anything accepted alongside it;
        // two entries accepted together are equal age
        a_old_n = a_keep & ~b_keep;
        b_old_n = b_keep & ~a_keep;

        if (acc_a) begin
            a_addr_n = A_ADDR;
            a_data_n = A_DATA;
        end
        if (acc_b) begin
            b_addr_n = B_ADDR;
            b_data_n = B_DATA;
        end

        if (grant_a) begin
            write_n     = 1'b1;
            inaddress_n = a_addr;
            in_n        = a_data;
        end else if (grant_b) begin
            write_n     = 1'b1;
            inaddress_n = b_addr;
            in_n        = b_data;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            a_full    <= 1'b0;
            b_full    <= 1'b0;
            a_addr    <= '0;
            b_addr    <= '0;
            a_data    <= '0;
            b_data    <= '0;
            a_old     <= 1'b0;
            b_old     <= 1'b0;
            rr_b      <= 1'b0;
            WRITE     <= 1'b0;
            INADDRESS <= '0;
            IN        <= '0;
        end else begin
            a_full    <= a_full_n;
            b_full    <= b_full_n;
            a_addr    <= a_addr_n;
            b_addr    <= b_addr_n;
            a_data    <= a_data_n;
            b_data    <= b_data_n;
            a_old     <= a_old_n;
            b_old     <= b_old_n;
            rr_b      <= rr_b_n;
            WRITE     <= write_n;
            INADDRESS <= inaddress_n;
            IN        <= in_n;
        end
    end

    // Read-after-write hazard flags; register 0 is checked like any other
    assign HAZ1 = (a_full & (a_addr == RD1_ADDR)) |
                  (b_full & (b_addr == RD1_ADDR)) |
                  (WRITE & (INADDRESS == RD1_ADDR));
    assign HAZ2 = (a_full & (a_addr == RD2_ADDR)) |
                  (b_full & (b_addr == RD2_ADDR)) |
                  (WRITE & (INADDRESS == RD2_ADDR));

    assign BUSY = a_full | b_full | WRITE;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter with a behavioural reg_file
// that commits on each WRITE pulse.
module tb_regfile_write_arbiter;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              A_VALID, B_VALID;
    logic [ADDR_W-1:0] A_ADDR, B_ADDR;
    logic [DATA_W-1:0] A_DATA, B_DATA;
    logic              A_READY, B_READY;
    logic              WRITE;
    logic [ADDR_W-1:0] INADDRESS;
    logic [DATA_W-1:0] IN;
    logic [ADDR_W-1:0] RD1_ADDR, RD2_ADDR;
    logic              HAZ1, HAZ2, BUSY;

    int n_checks = 0;
    int n_pass   = 0;
    int n_writes = 0;
    logic [DATA_W-1:0] rf [2**ADDR_W];

    regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RESET(RESET),
        .A_VALID(A_VALID), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_READY(A_READY),
        .B_VALID(B_VALID), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_READY(B_READY),
        .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
        .RD1_ADDR(RD1_ADDR), .RD2_ADDR(RD2_ADDR),
        .HAZ1(HAZ1), .HAZ2(HAZ2), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // reg_file model
    always @(posedge CLK) begin
        if (WRITE) begin
            rf[INADDRESS] <= IN;
            n_writes <= n_writes + 1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        A_VALID = 1'b0; B_VALID = 1'b0;
    endtask

    // Expect a write pulse with given address/data at the current sample point
    task automatic expect_write(input string name, input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ed);
        n_checks++;
        if ({WRITE, INADDRESS, IN} !== {1'b1, ea, ed})
            $display("FAIL %s: got WRITE=%0b addr=%0d data=%h, expected WRITE=1 addr=%0d data=%h",
                     name, WRITE, INADDRESS, IN, ea, ed);
        else n_pass++;
    endtask

    task automatic test_reset();
        idle_inputs();
        A_ADDR = '0; A_DATA = '0; B_ADDR = '0; B_DATA = '0;
        RD1_ADDR = '0; RD2_ADDR = '0;
        RESET = 1'b1;
        tick(); tick();
        n_checks++;
        if ({WRITE, INADDRESS, IN, BUSY} !== '0)
            $display("FAIL reset_out: got WRITE=%0b addr=%0d data=%h BUSY=%0b, expected all 0", WRITE, INADDRESS, IN, BUSY);
        else n_pass++;
        n_checks++;
        if ({A_READY, B_READY} !== 2'b00)
            $display("FAIL reset_ready: got %b, expected 00", {A_READY, B_READY});
        else n_pass++;
        RESET = 1'b0;
        #1;
        n_checks++;
        if ({A_READY, B_READY} !== 2'b11)
            $display("FAIL ready_after_reset: got %b, expected 11", {A_READY, B_READY});
        else n_pass++;
    endtask

    task automatic test_single();
        A_VALID = 1'b1; A_ADDR = 3'd3; A_DATA = 8'h5A;
        tick();
        idle_inputs();
        n_checks++;
        if ({A_READY, WRITE, BUSY} !== 3'b001)
            $display("FAIL single_accept: got READY/WRITE/BUSY=%b, expected 001", {A_READY, WRITE, BUSY});
        else n_pass++;
        tick();
        expect_write("single_write", 3'd3, 8'h5A);
        n_checks++;
        if (A_READY !== 1'b1)
            $display("FAIL single_ready_back: got %b, expected 1", A_READY);
        else n_pass++;
        tick();
        n_checks++;
        if ({WRITE, BUSY, INADDRESS, IN} !== {1'b0, 1'b0, 3'd3, 8'h5A})
            $display("FAIL single_done: got WRITE=%0b BUSY=%0b addr=%0d data=%h, expected 0 0 3 5a", WRITE, BUSY, INADDRESS, IN);
        else n_pass++;
        n_checks++;
        if (rf[3] !== 8'h5A)
            $display("FAIL single_commit: got r3=%h, expected 5a", rf[3]);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        A_VALID = 1'b1; A_ADDR = 3'd1; A_DATA = 8'h11;
        B_VALID = 1'b1; B_ADDR = 3'd2; B_DATA = 8'h22;
        tick();
        idle_inputs();
        tick();
        expect_write("rr_first_a", 3'd1, 8'h11);
        n_checks++;
        if ({A_READY, B_READY} !== 2'b10)
            $display("FAIL rr_ready: got %b, expected 10", {A_READY, B_READY});
        else n_pass++;
        tick();
        expect_write("rr_then_b", 3'd2, 8'h22);
        A_VALID = 1'b1; A_ADDR = 3'd4; A_DATA = 8'h44;
        B_VALID = 1'b1; B_ADDR = 3'd5; B_DATA = 8'h55;
        tick();
        idle_inputs();
        n_checks++;
        if (WRITE !== 1'b0)
            $display("FAIL rr_gap: got WRITE=%0b, expected 0", WRITE);
        else n_pass++;
        tick();
        expect_write("rr_first_b", 3'd5, 8'h55);
        tick();
        expect_write("rr_then_a", 3'd4, 8'h44);
        tick();
        n_checks++;
        if ({WRITE, BUSY} !== 2'b00)
            $display("FAIL rr_idle: got WRITE/BUSY=%b, expected 00", {WRITE, BUSY});
        else n_pass++;
    endtask

    task automatic test_age();
        B_VALID = 1'b1; B_ADDR = 3'd6; B_DATA = 8'h66;
        tick();
        B_VALID = 1'b0;
        A_VALID = 1'b1; A_ADDR = 3'd7; A_DATA = 8'h77;
        tick();
        idle_inputs();
        expect_write("age_b_first", 3'd6, 8'h66);
        n_checks++;
        if ({A_READY, B_READY} !== 2'b01)
            $display("FAIL age_ready: got %b, expected 01", {A_READY, B_READY});
        else n_pass++;
        tick();
        expect_write("age_a_second", 3'd7, 8'h77);
        tick();
    endtask

    task automatic test_same_addr();
        A_VALID = 1'b1; A_ADDR = 3'd4; A_DATA = 8'hAA;
        B_VALID = 1'b1; B_ADDR = 3'd4; B_DATA = 8'hBB;
        tick();
        idle_inputs();
        tick();
        expect_write("same_addr_a", 3'd4, 8'hAA);
        tick();
        expect_write("same_addr_b", 3'd4, 8'hBB);
        tick();
        n_checks++;
        if (rf[4] !== 8'hBB)
            $display("FAIL same_addr_commit: got r4=%h, expected bb", rf[4]);
        else n_pass++;
    endtask

    task automatic test_hazard();
        RD1_ADDR = 3'd5; RD2_ADDR = 3'd0;
        #1;
        n_checks++;
        if ({HAZ1, HAZ2} !== 2'b00)
            $display("FAIL haz_idle: got %b, expected 00", {HAZ1, HAZ2});
        else n_pass++;
        B_VALID = 1'b1; B_ADDR = 3'd5; B_DATA = 8'h5C;
        tick();
        idle_inputs();
        n_checks++;
        if ({HAZ1, HAZ2} !== 2'b10)
            $display("FAIL haz_buffered: got %b, expected 10", {HAZ1, HAZ2});
        else n_pass++;
        tick();
        n_checks++;
        if ({WRITE, HAZ1, HAZ2} !== 3'b110)
            $display("FAIL haz_inflight: got WRITE/HAZ1/HAZ2=%b, expected 110", {WRITE, HAZ1, HAZ2});
        else n_pass++;
        tick();
        n_checks++;
        if ({HAZ1, HAZ2} !== 2'b00)
            $display("FAIL haz_cleared: got %b, expected 00", {HAZ1, HAZ2});
        else n_pass++;
        // Register 0 is not exempt
        A_VALID = 1'b1; A_ADDR = 3'd0; A_DATA = 8'h01;
        tick();
        idle_inputs();
        n_checks++;
        if ({HAZ1, HAZ2} !== 2'b01)
            $display("FAIL haz_reg0: got %b, expected 01", {HAZ1, HAZ2});
        else n_pass++;
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        int writes_before;
        A_VALID = 1'b1; A_ADDR = 3'd1; A_DATA = 8'hE1;
        B_VALID = 1'b1; B_ADDR = 3'd2; B_DATA = 8'hE2;
        tick();
        idle_inputs();
        RESET = 1'b1;
        #1;
        n_checks++;
        if ({A_READY, B_READY, BUSY} !== 3'b001)
            $display("FAIL rst_mid_pre: got READY_A/READY_B/BUSY=%b, expected 001", {A_READY, B_READY, BUSY});
        else n_pass++;
        tick();
        RESET = 1'b0;
        writes_before = n_writes;
        n_checks++;
        if ({WRITE, BUSY, INADDRESS, IN} !== '0)
            $display("FAIL rst_mid_out: got WRITE=%0b BUSY=%0b addr=%0d data=%h, expected all 0", WRITE, BUSY, INADDRESS, IN);
        else n_pass++;
        #1;
        n_checks++;
        if ({A_READY, B_READY} !== 2'b11)
            $display("FAIL rst_mid_ready: got %b, expected 11", {A_READY, B_READY});
        else n_pass++;
        tick(); tick(); tick();
        n_checks++;
        if (n_writes !== writes_before || WRITE !== 1'b0)
            $display("FAIL rst_mid_nowrite: got %0d extra writes (WRITE=%0b), expected 0", n_writes - writes_before, WRITE);
        else n_pass++;
        n_checks++;
        if (rf[1] === 8'hE1 || rf[2] === 8'hE2)
            $display("FAIL rst_mid_discard: got r1=%h r2=%h, expected neither e1 nor e2", rf[1], rf[2]);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) rf[i] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_age();
        test_same_addr();
        test_hazard();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
